axi_pcie_bram_slave: RTL and testbench

//   AXI4 memory-mapped slave consuming the PCIe bridge master port (m_axi_pcie, 128-bit data,
//   32-bit address). Backs BAR accesses with an on-chip block-RAM window of DEPTH x 128-bit words.

---
 rtl/axi_pcie_bram_slave_if.sv | 74 +++++++
 rtl/axi_pcie_bram_slave.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axi_pcie_bram_slave.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pcie_bram_slave_if.sv
// ---------------------------------------------------------------------------
// axi_pcie_bram_slave_if
//   AXI4 memory-mapped bus carrying PCIe bridge BAR traffic into the block-RAM
//   slave. Only the fields the slave acts on are carried; protection, lock
//   and cache attributes are not needed by a plain memory window.
//
//   Write address : awaddr, awlen, awsize, awburst, awvalid / awready
//   Write data    : wdata, wstrb, wlast, wvalid / wready
//   Write resp    : bresp, bvalid / bready
//   Read address  : araddr, arlen, arsize, arburst, arvalid / arready
//   Read data     : rdata, rresp, rlast, rvalid / rready
//
//   Modports: master (bridge side), slave (memory side).
// ---------------------------------------------------------------------------
interface axi_pcie_bram_slave_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_pcie_bram_slave.sv
// ---------------------------------------------------------------------------
// axi_pcie_bram_slave
//   AXI4 slave backing PCIe BAR accesses with a DEPTH x 128-bit block RAM.
//   One transaction at a time; single and FIXED/INCR/WRAP bursts. Upper
//   address bits above the window are ignored, so the window aliases.
//
//   Ports:
//     axi_clk_pcie : clock, everything on the rising edge
//     sys_reset    : synchronous active-high reset
//     s_axi        : AXI4 slave modport (see axi_pcie_bram_slave_if)
//
//   Read path: RAM read is registered (1 cycle), then lands in a 2-entry
//   output buffer that drives rdata/rlast/rvalid, so back-pressure on rready
//   never drops or repeats a beat and full throughput is kept when rready=1.
// ---------------------------------------------------------------------------
module axi_pcie_bram_slave #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32
) (
    input  logic                  axi_clk_pcie,
    input  logic                  sys_reset,
    axi_pcie_bram_slave_if.slave  s_axi
);
    localparam int         IDX_W       = $clog2(DEPTH);
    localparam int         STRB_W      = DATA_W / 8;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_DATA
    } state_t;

    // Byte address of the next beat. WRAP with an illegal length degrades to INCR.
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        step = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        if (burst == BURST_FIXED) begin
            return addr;
        end else if (burst == BURST_WRAP &&
                     (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            return (addr & ~mask) | ((addr + step) & mask);
        end else begin
            return addr + step;
        end
    endfunction

    // Control state
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [7:0]        cnt_q, cnt_d;        // write beat / read issue counter
    logic              err_q, err_d;        // wlast misplaced on some beat
    logic              last_wr_q, last_wr_d; // last grant went to the write channel
    logic              iss_done_q, iss_done_d;

    // Read return pipeline
    logic              pend_q, pend_d;      // mem_rd_q holds a beat to push
    logic              pend_last_q, pend_last_d;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [DATA_W-1:0] fifo_data_d [2];
    logic [1:0]        fifo_last_q, fifo_last_d;
    logic              wptr_q, wptr_d;
    logic              rptr_q, rptr_d;
    logic [1:0]        fcnt_q, fcnt_d;

    // Memory
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_rd_q;
    logic              mem_we;
    logic              mem_re;
    logic [IDX_W-1:0]  word_idx;

    logic              grant_wr;
    logic              grant_rd;
    logic              rvalid_w;
    logic              pop;
    logic [2:0]        occ;

    assign word_idx = addr_q[4 +: IDX_W];

    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        last_wr_d   = last_wr_q;
        iss_done_d  = iss_done_q;
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        grant_wr    = 1'b0;
        grant_rd    = 1'b0;

        rvalid_w = (fcnt_q != 2'd0);
        pop      = rvalid_w && s_axi.rready;
        // Slots committed after this edge: buffered + in flight - leaving now.
        occ      = 3'(fcnt_q) + 3'(pend_q) - 3'(pop);

        s_axi.awready = 1'b0;
        s_axi.arready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        s_axi.bresp   = RESP_OKAY;
        s_axi.rvalid  = rvalid_w;
        s_axi.rdata   = fifo_data_q[rptr_q];
        s_axi.rlast   = rvalid_w && fifo_last_q[rptr_q];
        s_axi.rresp   = RESP_OKAY;

        unique case (state_q)
            ST_IDLE: begin
                // Round-robin on contention; after reset the read side counts as last served.
                grant_wr = !sys_reset && s_axi.awvalid && (!s_axi.arvalid || !last_wr_q);
                grant_rd = !sys_reset && s_axi.arvalid && !grant_wr;
                s_axi.awready = grant_wr;
                s_axi.arready = grant_rd;
                if (grant_wr) begin
                    addr_d    = s_axi.awaddr;
                    len_d     = s_axi.awlen;
                    size_d    = s_axi.awsize;
                    burst_d   = s_axi.awburst;
                    cnt_d     = 8'd0;
                    err_d     = 1'b0;
                    last_wr_d = 1'b1;
                    state_d   = ST_WR_DATA;
                end else if (grant_rd) begin
                    addr_d     = s_axi.araddr;
                    len_d      = s_axi.arlen;
                    size_d     = s_axi.arsize;
                    burst_d    = s_axi.arburst;
                    cnt_d      = 8'd0;
                    iss_done_d = 1'b0;
                    last_wr_d  = 1'b0;
                    state_d    = ST_RD_DATA;
                end
            end

            ST_WR_DATA: begin
                s_axi.wready = 1'b1;
                if (s_axi.wvalid) begin
                    mem_we = 1'b1;
                    err_d  = err_q || (s_axi.wlast != (cnt_q == len_q));
                    // The beat count, not wlast, decides where the burst ends.
                    if (cnt_q == len_q) begin
                        state_d = ST_WR_RESP;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        addr_d = next_addr(addr_q, len_q, size_q, burst_q);
                    end
                end
            end

            ST_WR_RESP: begin
                s_axi.bvalid = 1'b1;
                s_axi.bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (s_axi.bready) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RD_DATA: begin
                if (!iss_done_q && occ < 3'd2) begin
                    mem_re = 1'b1;
                    if (cnt_q == len_q) begin
                        iss_done_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        addr_d = next_addr(addr_q, len_q, size_q, burst_q);
                    end
                end
                if (pop && fifo_last_q[rptr_q]) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        pend_d      = mem_re;
        pend_last_d = mem_re && (cnt_q == len_q);
        if (pend_q) begin
            fifo_data_d[wptr_q] = mem_rd_q;
            fifo_last_d[wptr_q] = pend_last_q;
            wptr_d              = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        fcnt_d = fcnt_q + 2'(pend_q) - 2'(pop);
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge axi_clk_pcie) begin
        if (sys_reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            len_q          <= '0;
            size_q         <= '0;
            burst_q        <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            last_wr_q      <= 1'b0;
            iss_done_q     <= 1'b1;
            pend_q         <= 1'b0;
            pend_last_q    <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            wptr_q         <= 1'b0;
            rptr_q         <= 1'b0;
            fcnt_q         <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            last_wr_q   <= last_wr_d;
            iss_done_q  <= iss_done_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fcnt_q      <= fcnt_d;
        end
    end

    // NOTE: the RAM array and its read register have no reset so they map onto block RAM; contents survive sys_reset.
    always_ff @(posedge axi_clk_pcie) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (s_axi.wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= s_axi.wdata[8*i +: 8];
                end
            end
        end
        if (mem_re) begin
            mem_rd_q <= mem[word_idx];
        end
    end

endmodule

// File: tb/tb_axi_pcie_bram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_pcie_bram_slave
//   Directed bench for axi_pcie_bram_slave. Inputs change on the falling
//   edge; outputs are sampled 1 time unit after the falling edge, half a
//   cycle away from the rising edge where the DUT acts.
// ---------------------------------------------------------------------------
module tb_axi_pcie_bram_slave;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [127:0] D1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D4  = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
    localparam logic [127:0] D4B = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
    localparam logic [127:0] ONES = {128{1'b1}};

    logic clk = 1'b0;
    logic sys_reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic both_seen = 1'b0;

    logic [127:0] rd_data [16];
    logic         rd_last [16];
    logic [1:0]   rd_resp [16];
    int           rd_n;
    logic [1:0]   bresp_got;

    axi_pcie_bram_slave_if #(.DATA_W(128), .ADDR_W(32)) bus ();

    axi_pcie_bram_slave #(.DEPTH(1024), .DATA_W(128), .ADDR_W(32)) dut (
        .axi_clk_pcie (clk),
        .sys_reset    (sys_reset),
        .s_axi        (bus)
    );

    always #5 clk = ~clk;

    // Readies must never both be high; sampled just before each rising edge.
    always @(negedge clk) begin
        #4;
        if (bus.awready && bus.arready) both_seen = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All transaction tasks start and end on a falling edge.
    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic got = 1'b0;
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awsize  = size;
        bus.awburst = burst;
        bus.awvalid = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            #1 got = bus.awready;
            @(negedge clk);
        end
        bus.awvalid = 1'b0;
        check("aw_handshake", 128'(got), 128'(1));
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic got = 1'b0;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            #1 got = bus.arready;
            @(negedge clk);
        end
        bus.arvalid = 1'b0;
        check("ar_handshake", 128'(got), 128'(1));
    endtask

    task automatic send_w(input logic [127:0] data, input logic [15:0] strb, input logic last);
        logic got = 1'b0;
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wlast  = last;
        bus.wvalid = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            #1 got = bus.wready;
            @(negedge clk);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        if (!got) check("w_handshake", 128'(got), 128'(1));
    endtask

    task automatic get_b();
        logic got = 1'b0;
        bus.bready = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            #1 got = bus.bvalid;
            bresp_got = bus.bresp;
            @(negedge clk);
        end
        bus.bready = 1'b0;
        if (!got) check("b_handshake", 128'(got), 128'(1));
    endtask

    // Collect n read beats; toggle=1 drops rready every other cycle.
    task automatic get_r(input int n, input logic toggle);
        rd_n = 0;
        for (int cyc = 0; cyc < 400 && rd_n < n; cyc++) begin
            bus.rready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (bus.rvalid && bus.rready) begin
                rd_data[rd_n] = bus.rdata;
                rd_last[rd_n] = bus.rlast;
                rd_resp[rd_n] = bus.rresp;
                rd_n++;
            end
            @(negedge clk);
        end
        bus.rready = 1'b0;
        check("r_beat_count", 128'(rd_n), 128'(n));
    endtask

    initial begin
        logic [127:0] exp_word;

        sys_reset   = 1'b1;
        bus.awaddr  = '0; bus.awlen = '0; bus.awsize = 3'd4; bus.awburst = INCR;
        bus.araddr  = '0; bus.arlen = '0; bus.arsize = 3'd4; bus.arburst = INCR;
        bus.wdata   = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready  = 1'b0; bus.rready = 1'b0;
        // Valids held high during reset: readies must still stay low.
        bus.awvalid = 1'b1;
        bus.arvalid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_awready", 128'(bus.awready), 128'(0));
        check("rst_arready", 128'(bus.arready), 128'(0));
        check("rst_wready",  128'(bus.wready),  128'(0));
        check("rst_bvalid",  128'(bus.bvalid),  128'(0));
        check("rst_bresp",   128'(bus.bresp),   128'(0));
        check("rst_rvalid",  128'(bus.rvalid),  128'(0));
        check("rst_rlast",   128'(bus.rlast),   128'(0));
        check("rst_rresp",   128'(bus.rresp),   128'(0));
        check("rst_rdata",   bus.rdata,         128'(0));
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.arvalid = 1'b0;
        sys_reset   = 1'b0;
        @(negedge clk);

        // 1: single write / read at 0x10
        send_aw(32'h10, 8'd0, 3'd4, INCR);
        send_w(D1, 16'hFFFF, 1'b1);
        get_b();
        check("t1_bresp", 128'(bresp_got), 128'(OKAY));
        send_ar(32'h10, 8'd0, 3'd4, INCR);
        get_r(1, 1'b0);
        check("t1_rdata", rd_data[0], D1);
        check("t1_rlast", 128'(rd_last[0]), 128'(1));
        check("t1_rresp", 128'(rd_resp[0]), 128'(OKAY));
        check("t1_idle_rvalid", 128'(bus.rvalid), 128'(0));

        // 2: INCR len=15 write words 0x10..0x1F with data i, read back with rready toggling
        send_aw(32'h100, 8'd15, 3'd4, INCR);
        for (int i = 0; i < 16; i++) send_w(128'(i), 16'hFFFF, (i == 15));
        get_b();
        check("t2_bresp", 128'(bresp_got), 128'(OKAY));
        send_ar(32'h100, 8'd15, 3'd4, INCR);
        get_r(16, 1'b1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t2_rdata_%0d", i), rd_data[i], 128'(i));
            check($sformatf("t2_rlast_%0d", i), 128'(rd_last[i]), 128'(i == 15));
        end
        check("t2_idle_rvalid", 128'(bus.rvalid), 128'(0));

        // 3: WRAP len=3 read at 0x120 -> words 0x12,0x13,0x10,0x11 (data 2,3,0,1)
        send_ar(32'h120, 8'd3, 3'd4, WRAP);
        get_r(4, 1'b0);
        check("t3_beat0", rd_data[0], 128'(2));
        check("t3_beat1", rd_data[1], 128'(3));
        check("t3_beat2", rd_data[2], 128'(0));
        check("t3_beat3", rd_data[3], 128'(1));
        check("t3_rlast2", 128'(rd_last[2]), 128'(0));
        check("t3_rlast3", 128'(rd_last[3]), 128'(1));

        // 4: simultaneous AW/AR; last grant was a read, so write first, then read
        bus.awaddr = 32'h300; bus.awlen = 8'd0; bus.awsize = 3'd4; bus.awburst = INCR;
        bus.araddr = 32'h10;  bus.arlen = 8'd0; bus.arsize = 3'd4; bus.arburst = INCR;
        bus.awvalid = 1'b1;
        bus.arvalid = 1'b1;
        #1;
        check("t4a_awready", 128'(bus.awready), 128'(1));
        check("t4a_arready", 128'(bus.arready), 128'(0));
        @(negedge clk);
        bus.awvalid = 1'b0;
        send_w(D4, 16'hFFFF, 1'b1);
        get_b();
        check("t4a_bresp", 128'(bresp_got), 128'(OKAY));
        bus.awaddr  = 32'h310;
        bus.awvalid = 1'b1;
        #1;
        check("t4b_awready", 128'(bus.awready), 128'(0));
        check("t4b_arready", 128'(bus.arready), 128'(1));
        @(negedge clk);
        bus.arvalid = 1'b0;
        get_r(1, 1'b0);
        check("t4b_rdata", rd_data[0], D1);
        send_aw(32'h310, 8'd0, 3'd4, INCR);
        send_w(D4B, 16'hFFFF, 1'b1);
        get_b();
        check("t4c_bresp", 128'(bresp_got), 128'(OKAY));
        send_ar(32'h300, 8'd1, 3'd4, INCR);
        get_r(2, 1'b0);
        check("t4_rd300", rd_data[0], D4);
        check("t4_rd310", rd_data[1], D4B);
        check("t4_never_both_ready", 128'(both_seen), 128'(0));

        // 5: partial strobe over all-ones, then misplaced wlast
        send_aw(32'h40, 8'd0, 3'd4, INCR);
        send_w(ONES, 16'hFFFF, 1'b1);
        get_b();
        send_aw(32'h40, 8'd0, 3'd4, INCR);
        send_w(128'h0, 16'h000F, 1'b1);
        get_b();
        check("t5_strb_bresp", 128'(bresp_got), 128'(OKAY));
        exp_word = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000;
        send_ar(32'h40, 8'd0, 3'd4, INCR);
        get_r(1, 1'b0);
        check("t5_strb_rdata", rd_data[0], exp_word);

        send_aw(32'h200, 8'd3, 3'd4, INCR);
        for (int i = 0; i < 4; i++) send_w(128'(32'hA0 + i), 16'hFFFF, (i == 1));
        get_b();
        check("t5_wlast_bresp", 128'(bresp_got), 128'(SLVERR));
        send_ar(32'h200, 8'd3, 3'd4, INCR);
        get_r(4, 1'b0);
        for (int i = 0; i < 4; i++)
            check($sformatf("t5_wlast_rd_%0d", i), rd_data[i], 128'(32'hA0 + i));

        // 6: reset after beat 2 of a len=7 read
        send_ar(32'h100, 8'd7, 3'd4, INCR);
        get_r(3, 1'b0);
        check("t6_beat2", rd_data[2], 128'(2));
        sys_reset = 1'b1;
        @(negedge clk);
        #1;
        check("t6_rst_rvalid", 128'(bus.rvalid), 128'(0));
        check("t6_rst_rlast",  128'(bus.rlast),  128'(0));
        @(negedge clk);
        sys_reset = 1'b0;
        @(negedge clk);
        send_ar(32'h40, 8'd0, 3'd4, INCR);
        get_r(1, 1'b0);
        check("t6_mem_40", rd_data[0], exp_word);
        send_ar(32'h130, 8'd0, 3'd4, INCR);
        get_r(1, 1'b0);
        check("t6_mem_130", rd_data[0], 128'(3));
        check("t6_rlast", 128'(rd_last[0]), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
